spi_rx_fifo: RTL
================

// Module: spi_rx_fifo
// PURPOSE
//  Parametrised receive FIFO between the SPI byte deserialiser and the SD/CPU-side reader.
//  - Captures one word per rising edge of the write strobe.
//  - Stores words in a circular buffer and returns them oldest-first on request.
//  - Reports fill level, full/empty, and sticky overflow/underflow errors.
//  - Replaces the fixed 8-byte shift buffer with a true FIFO of configurable width and depth.
// PARAMETERS
//  DATA_W  8  word width in bits
//  ADDR_W  3  pointer width; DEPTH = 2**ADDR_W entries (DEPTH >= 2)
// PORTS
//  clk        in   1         system clock, all logic on posedge
//  rst        in   1         synchronous active-high reset
//  flush      in   1         synchronous clear of contents and error flags
//  wr_strobe  in   1         write strobe from deserialiser; only its rising edge writes
//  wr_data    in   DATA_W    word accompanying wr_strobe
//  rd_req     in   1         pop request, one word per cycle while high
//  rd_valid   out  1         one-cycle pulse: rd_data holds a newly popped word
//  rd_data    out  DATA_W    last popped word, held until the next pop
//  count      out  ADDR_W+1  words stored, 0..DEPTH
//  empty      out  1         count == 0
//  full       out  1         count == DEPTH
//  overflow   out  1         sticky: a write was dropped because the FIFO was full
//  underflow  out  1         sticky: rd_req was seen while the FIFO was empty
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - Pointers, count, rd_data, rd_valid, overflow, underflow and strobe sync regs go to 0.
//   - empty=1, full=0.
//   - Memory contents are don't-care.
//   - rst overrides all other inputs.
//  Write path:
//   - Cycle t: wr_strobe and wr_data are registered (s1, d1); s2 <= s1.
//   - A push is qualified when s1 & ~s2.
//   - The push commits d1 at the end of cycle t+1, so count is visible at t+2.
//   - A held strobe writes once; a new write needs wr_strobe low for >= 1 cycle.
//  Read path:
//   - rd_req at cycle t with count > 0 (as registered at t): rd_data <= mem[rd_ptr] and rd_valid = 1 at t+1.
//   - rd_ptr and count update at the same edge.
//   - rd_valid is low in every other cycle.
//  Empty read:
//   - rd_req with count == 0: no pop, rd_valid stays 0, rd_data unchanged, underflow <= 1.
//   - There is no write-to-read bypass: a push and a pop in the same cycle on an empty FIFO means the push succeeds and the pop is an underflow.
//  Full write:
//   - A qualified push with count == DEPTH and no simultaneous pop: word dropped, overflow <= 1, state unchanged.
//  Simultaneous push and pop with 0 < count <= DEPTH:
//   - Both occur; count is unchanged.
//   - When full, the push is accepted because the pop frees a slot.
//  Pointers:
//   - ADDR_W-bit wr_ptr and rd_ptr wrap modulo DEPTH.
//   - count is a separate ADDR_W+1-bit counter: +1 on push, -1 on pop, unchanged on both or neither.
//  Flush:
//   - Same effect as reset, except rd_data is kept and the strobe sync regs keep running.
//   - Has priority over push and pop in the same cycle.
//   - A strobe edge qualifying in the flush cycle is lost.
//  Outputs:
//   - empty and full are decoded combinationally from registered count.
//   - overflow and underflow clear only on rst or flush.
// TESTING
//  1 Reset then 3 strobe pulses with data 0x11, 0x22, 0x33, then rd_req x3
//    -> rd_data 0x11, 0x22, 0x33, each with a 1-cycle rd_valid; count 3->0; empty=1.
//  2 wr_strobe held high 5 cycles with data 0xA5
//    -> exactly one push; count=1.
//  3 DEPTH+1 writes (0x00..0x08, defaults)
//    -> full=1, count=8, overflow=1.
//    Then 8 reads -> 0x00..0x07 in order; 0x08 absent.
//  4 FIFO full; a qualified push and rd_req in the same cycle
//    -> pop returns the oldest word, new word stored, count stays 8, overflow stays 0.
//  5 rd_req on empty FIFO
//    -> rd_valid=0, rd_data unchanged, underflow=1.
//    Then flush -> underflow=0, count=0.
//  6 Write 12 words while reading continuously (pointer wrap past DEPTH)
//    -> output order matches input order.
//    rst mid-stream -> count=0, rd_valid=0, rd_data=0 next cycle.

Source files
------------

// File: rtl/spi_rx_fifo.sv
// Receive FIFO between the SPI byte deserialiser and the reader side.
// Pushes on each rising edge of the write strobe and pops oldest-first on rd_req.
module spi_rx_fifo #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wr_strobe,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_req,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   count,
   output logic              empty,
   output logic              full,
   output logic              overflow,
   output logic              underflow
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wrPtr;
   logic [ADDR_W-1:0] r_rdPtr;
   logic [ADDR_W:0]   r_count;
   logic [DATA_W-1:0] r_rdData;
   logic              r_rdValid;
   logic              r_overflow;
   logic              r_underflow;
   logic              r_s1;
   logic              r_s2;
   logic [DATA_W-1:0] r_d1;

   logic w_empty;
   logic w_full;
   logic w_pushReq;
   logic w_pop;
   logic w_push;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == DEPTH_C);
   assign w_pushReq = r_s1 & ~r_s2;
   assign w_pop     = rd_req & ~w_empty;
   // A full FIFO still takes a push when a pop frees a slot in the same cycle.
   assign w_push    = w_pushReq & (~w_full | w_pop);

   always_ff @(posedge clk) begin
      if (!rst && !flush && w_push) begin
         r_mem[r_wrPtr] <= r_d1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_count     <= '0;
         r_rdData    <= '0;
         r_rdValid   <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_s1        <= 1'b0;
         r_s2        <= 1'b0;
         r_d1        <= '0;
      end else begin
         r_s1 <= wr_strobe;
         r_s2 <= r_s1;
         r_d1 <= wr_data;
         // Flush drops contents and errors but keeps rd_data and the strobe synchroniser.
         if (flush) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_rdValid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
         end else begin
            r_rdValid <= w_pop;
            if (w_pop) begin
               r_rdData <= r_mem[r_rdPtr];
               r_rdPtr  <= r_rdPtr + 1'b1;
            end
            if (w_push) begin
               r_wrPtr <= r_wrPtr + 1'b1;
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
            if (w_pushReq && !w_push) begin
               r_overflow <= 1'b1;
            end
            if (rd_req && w_empty) begin
               r_underflow <= 1'b1;
            end
         end
      end
   end

   assign rd_valid  = r_rdValid;
   assign rd_data   = r_rdData;
   assign count     = r_count;
   assign empty     = w_empty;
   assign full      = w_full;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

endmodule
